// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/mem/writeback FSM.
// Optional illegal-opcode trap to HALT: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ResultSrc,
  output logic             retire,
  output logic             illegal,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , HALT   = 4'd10
`endif
  } state_t;

  state_t st_q, st_d;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       is_ld, is_st, is_r, is_i, is_br;
  logic       unused;

  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign f7b5  = instr[30];
  assign is_ld = op == 7'b0000011;
  assign is_st = op == 7'b0100011;
  assign is_r  = op == 7'b0110011;
  assign is_i  = op == 7'b0010011;
  assign is_br = op == 7'b1100011;

  assign unused = ^{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [2:0] alu_dec(
    input logic [2:0] f,
    input logic       s
  );
    logic [2:0] r;
    unique case (f)
      3'b000:  r = s ? 3'b001 : 3'b000;
      3'b111:  r = 3'b010;
      3'b110:  r = 3'b011;
      3'b010:  r = 3'b101;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= FETCH;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d       = st_q;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    retire     = 1'b0;
    ImmSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ResultSrc  = 2'b00;
    // Reset gates every output so an aborted instruction leaves no strobe.
    if (rst_n) begin
      ImmSrc = is_st ? 2'b01 : (is_br ? 2'b10 : 2'b00);
      unique case (st_q)
        FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
          if (mem_ready) st_d = DECODE;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          unique case (1'b1)
            is_ld, is_st: st_d = MEMADR;
            is_r:         st_d = EXECR;
            is_i:         st_d = EXECI;
            is_br:        st_d = BRANCH;
            default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
              st_d = HALT;
`else
              st_d   = FETCH;
              retire = 1'b1;
`endif
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          st_d    = is_st ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          if (mem_ready) st_d = MEMWB;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          retire    = 1'b1;
          st_d      = FETCH;
        end
        MEMWRITE: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = mem_ready;
          retire   = mem_ready;
          if (mem_ready) st_d = FETCH;
        end
        EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_dec(f3, f7b5);
          st_d       = ALUWB;
        end
        EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_dec(f3, 1'b0);
          st_d       = ALUWB;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          st_d     = FETCH;
        end
        BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          PCWrite    = (f3 == 3'b000) ? zero :
                       (f3 == 3'b001) ? !zero : 1'b0;
          retire     = 1'b1;
          st_d       = FETCH;
        end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        HALT: st_d = HALT;
`endif
        default: st_d = FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal = st_q == HALT;
`else
  assign illegal = 1'b0;
`endif

  assign state = st_q;

endmodule
